// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin scheduler that shares one UART transmitter between NUM_REQ byte
// sources. One requester is granted at a time. Its byte is latched and a single
// start pulse is issued. The frame is then tracked until the transmitter drops busy.
// A frame whose busy never rises is abandoned after BUSY_TIMEOUT cycles, and err_o pulses.
// Note that rstn_i is active-HIGH despite its name.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic                      clk100_i,
    input  logic                      rstn_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*DATA_W-1:0] data_i,
    output logic [NUM_REQ-1:0]        ack_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic                      tx_start_o,
    output logic [DATA_W-1:0]         tx_data_o,
    input  logic                      tx_busy_i,
    output logic                      active_o,
    output logic                      err_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [PTR_W-1:0] LAST_IDX    = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W:0]   NUM_REQ_EXT = (PTR_W + 1)'(NUM_REQ);
    localparam logic [CNT_W-1:0] CNT_LIMIT   = CNT_W'(BUSY_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    r_grant;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_tx_data;
    logic                r_tx_start;
    logic [NUM_REQ-1:0]  r_ack;
    logic [NUM_REQ-1:0]  r_done;
    logic                r_active;
    logic                r_err;

    state_t              w_state_next;
    logic [PTR_W-1:0]    w_ptr_next;
    logic [PTR_W-1:0]    w_grant_next;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic [DATA_W-1:0]   w_tx_data_next;
    logic                w_tx_start_next;
    logic [NUM_REQ-1:0]  w_ack_next;
    logic [NUM_REQ-1:0]  w_done_next;
    logic                w_active_next;
    logic                w_err_next;

    logic                w_found;
    logic [PTR_W-1:0]    w_winner;
    logic [PTR_W:0]      w_sum;
    logic [PTR_W-1:0]    w_idx;
    logic [DATA_W-1:0]   w_win_data;

    // One-hot decode of a requester index
    function automatic logic [NUM_REQ-1:0] f_onehot(input logic [PTR_W-1:0] idx);
        logic [NUM_REQ-1:0] v_oh;
        v_oh = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_oh[k] = (idx == PTR_W'(k));
        end
        return v_oh;
    endfunction

    // Round-robin search: first active request starting at r_ptr, wrapping
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        w_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, r_ptr} + (PTR_W + 1)'(i);
            if (w_sum >= NUM_REQ_EXT) begin
                w_idx = PTR_W'(w_sum - NUM_REQ_EXT);
            end else begin
                w_idx = PTR_W'(w_sum);
            end
            if (!w_found && req_i[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end else begin
                w_winner = w_winner;
            end
        end
    end

    // Select the winning requester's byte
    always_comb begin
        w_win_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_winner == PTR_W'(k)) begin
                w_win_data = data_i[k*DATA_W +: DATA_W];
            end else begin
                w_win_data = w_win_data;
            end
        end
    end

    // Saturating increment of the busy-rise timeout counter
    assign w_cnt_inc = (r_cnt == CNT_LIMIT) ? r_cnt : (r_cnt + CNT_W'(1));

    // Next-state and next-output logic of the grant/frame FSM
    always_comb begin
        w_state_next    = r_state;
        w_ptr_next      = r_ptr;
        w_grant_next    = r_grant;
        w_cnt_next      = r_cnt;
        w_tx_data_next  = r_tx_data;
        w_tx_start_next = 1'b0;
        w_ack_next      = '0;
        w_done_next     = '0;
        w_active_next   = r_active;
        w_err_next      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A frame already in flight that we do not own blocks the grant
                if (w_found && !tx_busy_i) begin
                    w_grant_next    = w_winner;
                    w_tx_data_next  = w_win_data;
                    w_tx_start_next = 1'b1;
                    w_ack_next      = f_onehot(w_winner);
                    w_active_next   = 1'b1;
                    w_state_next    = ST_START;
                end else begin
                    w_active_next   = 1'b0;
                end
            end
            ST_START: begin
                w_ptr_next    = (r_grant == LAST_IDX) ? PTR_W'(0) : (r_grant + PTR_W'(1));
                w_cnt_next    = '0;
                w_active_next = 1'b1;
                w_state_next  = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy_i) begin
                    w_state_next = ST_WAIT_DONE;
                end else begin
                    w_cnt_next = w_cnt_inc;
                    if (w_cnt_inc == CNT_LIMIT) begin
                        w_err_next    = 1'b1;
                        w_active_next = 1'b0;
                        w_state_next  = ST_IDLE;
                    end else begin
                        w_state_next  = ST_WAIT_BUSY;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy_i) begin
                    w_done_next   = f_onehot(r_grant);
                    w_active_next = 1'b0;
                    w_state_next  = ST_IDLE;
                end else begin
                    w_state_next  = ST_WAIT_DONE;
                end
            end
            default: begin
                w_active_next = 1'b0;
                w_state_next  = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update with synchronous reset
    always_ff @(posedge clk100_i) begin
        if (rstn_i) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_cnt      <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_ack      <= '0;
            r_done     <= '0;
            r_active   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ptr      <= w_ptr_next;
            r_grant    <= w_grant_next;
            r_cnt      <= w_cnt_next;
            r_tx_data  <= w_tx_data_next;
            r_tx_start <= w_tx_start_next;
            r_ack      <= w_ack_next;
            r_done     <= w_done_next;
            r_active   <= w_active_next;
            r_err      <= w_err_next;
        end
    end

    assign ack_o      = r_ack;
    assign done_o     = r_done;
    assign tx_start_o = r_tx_start;
    assign tx_data_o  = r_tx_data;
    assign active_o   = r_active;
    assign err_o      = r_err;

endmodule
